// File: rtl/imm_enc_pkg.sv
// Shared definitions for the RV32I instruction encoder: field widths,
// format codes, base opcodes, the request payload and one pack function
// per instruction format.
package imm_enc_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned FMT_W = 3;
  localparam int unsigned OPC_W = 7;
  localparam int unsigned REG_W = 5;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned F7_W  = 7;

  // Format selector codes; 6 and 7 are reserved and encode as R
  localparam logic [FMT_W-1:0] FMT_R = FMT_W'(0);
  localparam logic [FMT_W-1:0] FMT_I = FMT_W'(1);
  localparam logic [FMT_W-1:0] FMT_S = FMT_W'(2);
  localparam logic [FMT_W-1:0] FMT_B = FMT_W'(3);
  localparam logic [FMT_W-1:0] FMT_U = FMT_W'(4);
  localparam logic [FMT_W-1:0] FMT_J = FMT_W'(5);

  // Base opcodes recognised by the core's immediate generator
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

  // Raw request fields as captured by the first pipeline stage
  typedef struct packed {
    logic [FMT_W-1:0] fmt;
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [F3_W-1:0]  funct3;
    logic [F7_W-1:0]  funct7;
    logic [XLEN-1:0]  imm;
  } enc_req_t;

  function automatic logic [XLEN-1:0] pack_r(enc_req_t r);
    return {r.funct7, r.rs2, r.rs1, r.funct3, r.rd, r.opcode};
  endfunction

  function automatic logic [XLEN-1:0] pack_i(enc_req_t r);
    return {r.imm[11:0], r.rs1, r.funct3, r.rd, r.opcode};
  endfunction

  function automatic logic [XLEN-1:0] pack_s(enc_req_t r);
    return {r.imm[11:5], r.rs2, r.rs1, r.funct3, r.imm[4:0], r.opcode};
  endfunction

  function automatic logic [XLEN-1:0] pack_b(enc_req_t r);
    return {r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.funct3,
            r.imm[4:1], r.imm[11], r.opcode};
  endfunction

  function automatic logic [XLEN-1:0] pack_u(enc_req_t r);
    return {r.imm[31:12], r.rd, r.opcode};
  endfunction

  function automatic logic [XLEN-1:0] pack_j(enc_req_t r);
    return {r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12], r.rd, r.opcode};
  endfunction

endpackage

// File: rtl/imm_range_chk.sv
// Combinational immediate range checker: flags immediates that the chosen
// format cannot represent exactly, and reserved format codes.
//   fmt_i  format code
//   imm_i  32-bit two's complement immediate
//   err_c  range violation (combinational)
module imm_range_chk
  import imm_enc_pkg::*;
(
  input  logic [FMT_W-1:0] fmt_i,
  input  logic [XLEN-1:0]  imm_i,
  output logic             err_c
);

  logic sext12_ok;
  logic sext13_ok;
  logic sext21_ok;

  // A value is the sign extension of its low N bits when bits [31:N-1] agree
  assign sext12_ok = (&imm_i[31:11]) | ~(|imm_i[31:11]);
  assign sext13_ok = (&imm_i[31:12]) | ~(|imm_i[31:12]);
  assign sext21_ok = (&imm_i[31:20]) | ~(|imm_i[31:20]);

  always_comb begin
    err_c = 1'b1;
    case (fmt_i)
      FMT_R:        err_c = 1'b0;
      FMT_I, FMT_S: err_c = ~sext12_ok;
      FMT_B:        err_c = ~sext13_ok | imm_i[0];
      FMT_J:        err_c = ~sext21_ok | imm_i[0];
      FMT_U:        err_c = |imm_i[11:0];
      default:      err_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_instr_encoder.sv
// RV32I instruction encoder for the program loader. Packs opcode, register,
// funct and immediate fields into a 32-bit word through a two-stage
// valid/ready pipeline, tagging each word with a sequential byte address.
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   request handshake (in_ready is combinational)
//   in_fmt .. in_imm    raw instruction fields
//   out_valid/out_ready output handshake
//   out_instr/out_addr  encoded word and its byte address
//   out_err             immediate range violation flag
//   out_count           completed output handshakes (wraps)
// Optional: define IMM_RANGE_CHECK_EN to enable the immediate range check;
// otherwise out_err is always 0.
module imm_instr_encoder
  import imm_enc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FMT_W-1:0] in_fmt,
  input  logic [OPC_W-1:0] in_opcode,
  input  logic [REG_W-1:0] in_rd,
  input  logic [REG_W-1:0] in_rs1,
  input  logic [REG_W-1:0] in_rs2,
  input  logic [F3_W-1:0]  in_funct3,
  input  logic [F7_W-1:0]  in_funct7,
  input  logic [XLEN-1:0]  in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_instr,
  output logic [XLEN-1:0]  out_addr,
  output logic             out_err,
  output logic [CNT_W-1:0] out_count
);

  enc_req_t         in_req_c;
  enc_req_t         s1_q;
  logic             s1_valid_q;
  logic             s2_valid_q;
  logic [XLEN-1:0]  instr_d;
  logic [XLEN-1:0]  instr_q;
  logic             err_d;
  logic             err_q;
  logic [XLEN-1:0]  addr_q;
  logic [CNT_W-1:0] count_q;
  logic             s1_adv_c;
  logic             s2_adv_c;
  logic             out_hs_c;

  // Flow control: a stage may load when empty or when its consumer drains
  assign s2_adv_c = ~s2_valid_q | out_ready;
  assign s1_adv_c = ~s1_valid_q | s2_adv_c;
  assign in_ready = s1_adv_c;
  assign out_hs_c = s2_valid_q & out_ready;

  always_comb begin
    in_req_c        = '0;
    in_req_c.fmt    = in_fmt;
    in_req_c.opcode = in_opcode;
    in_req_c.rd     = in_rd;
    in_req_c.rs1    = in_rs1;
    in_req_c.rs2    = in_rs2;
    in_req_c.funct3 = in_funct3;
    in_req_c.funct7 = in_funct7;
    in_req_c.imm    = in_imm;
  end

  // Format-directed packing of the stage-1 fields
  always_comb begin
    instr_d = pack_r(s1_q);
    case (s1_q.fmt)
      FMT_I:   instr_d = pack_i(s1_q);
      FMT_S:   instr_d = pack_s(s1_q);
      FMT_B:   instr_d = pack_b(s1_q);
      FMT_U:   instr_d = pack_u(s1_q);
      FMT_J:   instr_d = pack_j(s1_q);
      default: instr_d = pack_r(s1_q);
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  imm_range_chk u_range_chk (
    .fmt_i (s1_q.fmt),
    .imm_i (s1_q.imm),
    .err_c (err_d)
  );
`else
  assign err_d = 1'b0;
`endif

  // Pipeline registers, output address and handshake counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      instr_q    <= '0;
      err_q      <= 1'b0;
      addr_q     <= BASE_ADDR;
      count_q    <= '0;
    end else begin
      if (s1_adv_c) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_q <= in_req_c;
        end
      end
      if (s2_adv_c) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          instr_q <= instr_d;
          err_q   <= err_d;
        end
      end
      if (out_hs_c) begin
        addr_q  <= addr_q + 32'd4;
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_instr = instr_q;
  assign out_err   = err_q;
  assign out_addr  = addr_q;
  assign out_count = count_q;

endmodule
